// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
// Shared types and default sizing for the store buffer slice.
//   SB_DEPTH   default number of buffered stores
//   SB_AW      default address width
//   SB_DW      default data width
//   sb_entry_t one buffered store {addr, data} at the default widths
package store_buffer_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if
// Bundles the pipeline store/load request, the data-memory drain handshake
// and the forwarding result of the store buffer.
//   memwrite/aluout/writedata   store request (aluout doubles as load address)
//   stall                       store request present but not accepted
//   mem_valid/mem_addr/mem_wdata/mem_ready   drain handshake to data memory
//   memread/fwd_hit/fwd_data    load forwarding port
// Modports: master = pipeline + memory side, slave = store buffer.
interface store_buffer_if
   import store_buffer_pkg::*;
#(
   parameter int AW = SB_AW,
   parameter int DW = SB_DW
);

   logic          memwrite;
   logic [AW-1:0] aluout;
   logic [DW-1:0] writedata;
   logic          stall;
   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic          memread;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;

   modport master (
      output memwrite, aluout, writedata, mem_ready, memread,
      input  stall, mem_valid, mem_addr, mem_wdata, fwd_hit, fwd_data
   );

   modport slave (
      input  memwrite, aluout, writedata, mem_ready, memread,
      output stall, mem_valid, mem_addr, mem_wdata, fwd_hit, fwd_data
   );

endinterface

// File: rtl/sb_fifo_ctrl.sv
// sb_fifo_ctrl
// Pointer and occupancy bookkeeping for the store buffer FIFO.
//   clk, reset      clock, synchronous active-high reset
//   i_push, i_pop   requested enqueue / dequeue this cycle
//   o_wrPtr         tail slot written by the next push
//   o_rdPtr         head slot offered to memory
//   o_count         occupied entries (0..DEPTH)
//   o_full, o_empty occupancy flags
module sb_fifo_ctrl
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   output logic [$clog2(DEPTH)-1:0]   o_wrPtr,
   output logic [$clog2(DEPTH)-1:0]   o_rdPtr,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_empty;
   logic          w_doPush;
   logic          w_doPop;

   // Guard the requests here as well so count can never overflow or
   // underflow whatever the caller does.
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign w_doPush = i_push & ~w_full;
   assign w_doPop  = i_pop & ~w_empty;

   // Pointers wrap naturally because DEPTH is a power of two; count moves
   // only when exactly one of push/pop happens.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_doPush && w_doPop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign o_wrPtr = r_wrPtr;
   assign o_rdPtr = r_rdPtr;
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/store_buffer.sv
// store_buffer
// Write buffer between the pipeline memory stage and data memory. Aligned
// stores are queued and drained in program order, one per accepted
// handshake; misaligned stores are dropped and flagged.
//   clk, reset       clock, synchronous active-high reset
//   sb_bus           store_buffer_if.slave (request, drain, forwarding)
//   o_count          occupied entries
//   o_misalign_err   sticky flag, a misaligned store was seen
// Build option: define STORE_BUFFER_FWD_EN to enable load forwarding from
// buffered stores; otherwise fwd_hit/fwd_data are held at zero.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic                    clk,
   input  logic                    reset,
   store_buffer_if.slave           sb_bus,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic                    o_misalign_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        r_entries [DEPTH];
   logic          r_misalignErr;
   logic [PW-1:0] w_wrPtr;
   logic [PW-1:0] w_rdPtr;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_aligned;
   logic          w_push;
   logic          w_pop;
   logic          w_fwdHit;
   logic [DW-1:0] w_fwdData;

   // A full buffer blocks the store even when the head drains this cycle.
   assign w_aligned = (sb_bus.aluout[1:0] == 2'b00);
   assign w_push    = sb_bus.memwrite & ~w_full & w_aligned;
   assign w_pop     = ~w_empty & sb_bus.mem_ready;

   sb_fifo_ctrl #(
      .DEPTH (DEPTH)
   ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .o_wrPtr (w_wrPtr),
      .o_rdPtr (w_rdPtr),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Entry storage has no reset: an entry is only meaningful while the
   // pointer window covers it, and reset empties that window.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_entries[w_wrPtr] <= '{addr: sb_bus.aluout, data: sb_bus.writedata};
      end
   end

   // Sticky misalignment flag; a stalled store is not yet examined.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_misalignErr <= 1'b0;
      end else if (sb_bus.memwrite && !w_full && !w_aligned) begin
         r_misalignErr <= 1'b1;
      end
   end

   assign sb_bus.stall     = sb_bus.memwrite & w_full;
   assign sb_bus.mem_valid = ~w_empty;
   assign sb_bus.mem_addr  = w_empty ? '0 : r_entries[w_rdPtr].addr;
   assign sb_bus.mem_wdata = w_empty ? '0 : r_entries[w_rdPtr].data;
   assign sb_bus.fwd_hit   = w_fwdHit;
   assign sb_bus.fwd_data  = w_fwdData;
   assign o_count          = w_count;
   assign o_misalign_err   = r_misalignErr;

`ifdef STORE_BUFFER_FWD_EN
   logic [PW-1:0] w_fwdIdx;

   // Walk entries from oldest to youngest so the last match wins, giving
   // the youngest store. Only registered entries are searched, so a store
   // pushed in the same cycle is not visible.
   always_comb begin
      w_fwdHit  = 1'b0;
      w_fwdData = '0;
      w_fwdIdx  = '0;
      if (sb_bus.memread) begin
         for (int k = 0; k < DEPTH; k++) begin
            w_fwdIdx = w_rdPtr + PW'(k);
            if ((CW'(k) < w_count) &&
                (r_entries[w_fwdIdx].addr[AW-1:2] == sb_bus.aluout[AW-1:2])) begin
               w_fwdHit  = 1'b1;
               w_fwdData = r_entries[w_fwdIdx].data;
            end
         end
      end
   end
`else
   logic w_unusedMemread;

   // Forwarding is compiled out; the load request is deliberately ignored.
   assign w_unusedMemread = sb_bus.memread;
   assign w_fwdHit        = 1'b0;
   assign w_fwdData       = '0;
`endif

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 memwrite  input  1  pipeline store request (memory stage).
REQ-007 aluout  input  AW  store byte address.
REQ-008 writedata  input  DW  store data.
REQ-009 stall  output  1  store request present but not accepted this cycle.
REQ-010 mem_valid  output  1  head entry offered to data memory.
REQ-011 mem_addr  output  AW  head entry address.
REQ-012 mem_wdata  output  DW  head entry data.
REQ-013 mem_ready  input  1  data memory accepts head entry.
REQ-014 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 misalign_err  output  1  sticky flag, misaligned store seen.
REQ-016 memread  input  1  load request (forwarding port).
REQ-017 fwd_hit  output  1  load address matches a buffered store.
REQ-018 fwd_data  output  DW  forwarded store data.

Function
REQ-019 Push: memwrite=1, count<DEPTH, aluout[1:0]=00 -> entry {aluout, writedata} written at tail same edge.
REQ-020 Full: count==DEPTH blocks push even if a pop occurs the same cycle; stall = memwrite & (count==DEPTH), combinational.
REQ-021 Misaligned store (aluout[1:0]!=00, not stalled): entry dropped, misalign_err set next edge, held until reset.
REQ-022 mem_valid = (count!=0); mem_addr/mem_wdata = head entry, stable while mem_valid & !mem_ready.
REQ-023 Pop on edge where mem_valid & mem_ready; mem_ready ignored when empty.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 Pointers wrap modulo DEPTH; count derived from push/pop, never exceeds DEPTH or underflows.
REQ-026 Stores drain strictly in program (FIFO) order; one entry per cycle maximum; first offer one cycle after push (no bypass).
REQ-027 Empty: mem_addr/mem_wdata drive 0.

Reset
REQ-028 reset=1 at edge: pointers, count, misalign_err cleared; all entries invalidated; buffered stores discarded.
REQ-029 Outputs during/after reset: stall=memwrite&0 -> 0, mem_valid=0, count=0, fwd_hit=0, fwd_data=0.
REQ-030 reset mid-drain (mem_valid & !mem_ready) aborts the offer; no pop recorded.

Configuration
REQ-031 Macro STORE_BUFFER_FWD_EN defined: memread with word-address match against valid entries -> fwd_hit=1, fwd_data = youngest matching entry, combinational; entry pushed this cycle not visible.
REQ-032 Macro undefined: memread ignored, fwd_hit=0, fwd_data=0 constantly; no compare logic.

Structure
REQ-033 Package store_buffer_pkg holds sb_entry_t struct {addr, data} and default DEPTH/AW/DW constants.
REQ-034 One sub-module sb_fifo_ctrl: pointers, count, full/empty; entry storage and forwarding compare in store_buffer.

Verification
REQ-035 Reset, push 0x100/0xDEADBEEF, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, then count=0.
REQ-036 mem_ready=0, push 5 stores (DEPTH=4) -> count=4, stall=1 on 5th, 5th not stored; raise mem_ready -> drain order 1..4.
REQ-037 count=2, push and mem_ready same cycle -> count stays 2, head advances.
REQ-038 Store to 0x102 -> not buffered, count unchanged, misalign_err=1 until reset.
REQ-039 FWD_EN: stores 0x200=0x11 then 0x200=0x22 buffered, memread at 0x200 -> fwd_hit=1, fwd_data=0x22; 0x204 -> fwd_hit=0.
REQ-040 3 entries buffered, mem_ready=0, assert reset -> count=0, mem_valid=0, no writes emitted after.
